// File: rtl/word_serializer.sv
// word_serializer: word-to-byte serializer with a one-word pending buffer; optional sticky overflow flag under WORD_SER_OVF_EN
module word_serializer #(
    parameter int BYTE_W         = 8,
    parameter int BYTES_PER_WORD = 2,
    parameter int WORD_W         = BYTE_W * BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              word_dv,
    input  logic [WORD_W-1:0] word,
    input  logic              msb_first,
    output logic              word_rdy,
    output logic              byte_dv,
    output logic [BYTE_W-1:0] byteee,
    input  logic              byte_rdy,
    output logic              busy,
    output logic              ovf,
    input  logic              ovf_clr
);
    localparam int CW = $clog2(BYTES_PER_WORD + 1);
    localparam logic [CW-1:0] FULL = CW'(BYTES_PER_WORD);
    typedef enum logic {IDLE, SEND} state_t;
    state_t            state, state_n;
    logic [WORD_W-1:0] act_sr, act_sr_n, pend_w, pend_w_n, rev_w, ld_w;
    logic [CW-1:0]     act_cnt, act_cnt_n;
    logic              pend_v, pend_v_n, accept, consume, last;
    genvar i;
    for (i = 0; i < BYTES_PER_WORD; i++) begin : g_rev
        assign rev_w[i*BYTE_W +: BYTE_W] = word[(BYTES_PER_WORD-1-i)*BYTE_W +: BYTE_W];
    end
    assign ld_w     = msb_first ? rev_w : word;
    assign word_rdy = !pend_v;
    assign byte_dv  = act_cnt != '0;
    assign byteee   = byte_dv ? act_sr[BYTE_W-1:0] : '0;
    assign busy     = byte_dv | pend_v;
    assign accept   = word_dv && word_rdy;
    assign consume  = byte_dv && byte_rdy;
    assign last     = consume && act_cnt == CW'(1);
    // state, active shift register and pending buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            act_sr  <= '0;
            act_cnt <= '0;
            pend_w  <= '0;
            pend_v  <= 1'b0;
        end else begin
            state   <= state_n;
            act_sr  <= act_sr_n;
            act_cnt <= act_cnt_n;
            pend_w  <= pend_w_n;
            pend_v  <= pend_v_n;
        end
    end
    // next state: load, shift out, refill from pending or same-edge word
    always_comb begin
        state_n   = state;
        act_sr_n  = act_sr;
        act_cnt_n = act_cnt;
        pend_w_n  = pend_w;
        pend_v_n  = pend_v;
        if (state == IDLE) begin
            if (accept) begin
                act_sr_n  = ld_w;
                act_cnt_n = FULL;
                state_n   = SEND;
            end
        end else if (last) begin
            if (pend_v) begin
                act_sr_n  = pend_w;
                act_cnt_n = FULL;
                pend_v_n  = 1'b0;
            end else if (accept) begin
                act_sr_n  = ld_w;
                act_cnt_n = FULL;
            end else begin
                act_sr_n  = act_sr >> BYTE_W;
                act_cnt_n = '0;
                state_n   = IDLE;
            end
        end else begin
            if (consume) begin
                act_sr_n  = act_sr >> BYTE_W;
                act_cnt_n = act_cnt - 1'b1;
            end
            if (accept) begin
                pend_w_n = ld_w;
                pend_v_n = 1'b1;
            end
        end
    end
`ifdef WORD_SER_OVF_EN
    // sticky overflow: a word offered while the pending buffer is full; set beats clear
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (word_dv && !word_rdy)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: scoreboard bench for word_serializer (2- and 4-byte instances)
module tb_word_serializer;
`ifdef WORD_SER_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst, word_dv, msb_first, byte_rdy, ovf_clr;
    logic [15:0] word;
    logic        word_rdy, byte_dv, busy, ovf;
    logic [7:0]  byteee;
    logic        word_dv4, msb4;
    logic [31:0] word4;
    logic        word_rdy4, byte_dv4, busy4, ovf4;
    logic [7:0]  byteee4;
    logic [7:0]  q[$];
    logic [7:0]  q4[$];
    int          n_chk = 0;
    int          n_pass = 0;

    word_serializer dut (
        .clk(clk), .rst(rst), .word_dv(word_dv), .word(word), .msb_first(msb_first),
        .word_rdy(word_rdy), .byte_dv(byte_dv), .byteee(byteee), .byte_rdy(byte_rdy),
        .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    word_serializer #(.BYTES_PER_WORD(4)) dut4 (
        .clk(clk), .rst(rst), .word_dv(word_dv4), .word(word4), .msb_first(msb4),
        .word_rdy(word_rdy4), .byte_dv(byte_dv4), .byteee(byteee4), .byte_rdy(1'b1),
        .busy(busy4), .ovf(ovf4), .ovf_clr(1'b0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        for (int i = 0; i < 40 && (q.size() != 0 || q4.size() != 0); i++) tick;
        tick;
        tick;
        chk("drain", 64'(q.size()), 0);
        chk("drain4", 64'(q4.size()), 0);
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && byte_dv && byte_rdy) begin
            e = 'x;
            if (q.size() != 0) e = 64'(q.pop_front());
            chk("byte", 64'(byteee), e);
        end
        if (!byte_dv) chk("idle_zero", 64'(byteee), 0);
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && byte_dv4) begin
            e = 'x;
            if (q4.size() != 0) e = 64'(q4.pop_front());
            chk("byte4", 64'(byteee4), e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1; word_dv = 0; word = '0; msb_first = 0; byte_rdy = 1; ovf_clr = 0;
        word_dv4 = 0; word4 = '0; msb4 = 0;
        tick; tick;
        rst = 0;
        chk("rst_dv", 64'(byte_dv), 0);
        chk("rst_byte", 64'(byteee), 0);
        chk("rst_rdy", 64'(word_rdy), 1);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ovf", 64'(ovf), 0);
        // 4-byte word, MS byte first
        word_dv4 = 1; word4 = 32'h11223344; msb4 = 1;
        q4.push_back(8'h11); q4.push_back(8'h22); q4.push_back(8'h33); q4.push_back(8'h44);
        tick;
        word_dv4 = 0;
        for (int k = 0; k < 4; k++) begin
            chk("w4_dv", 64'(byte_dv4), 1);
            tick;
        end
        chk("w4_end", 64'(byte_dv4), 0);
        // single word, LS byte first, latency 1
        word_dv = 1; word = 16'hA55A; msb_first = 0;
        q.push_back(8'h5A); q.push_back(8'hA5);
        tick;
        word_dv = 0;
        chk("a_lat", 64'(byte_dv), 1);
        chk("a_b0", 64'(byteee), 8'h5A);
        tick;
        chk("a_dv1", 64'(byte_dv), 1);
        chk("a_b1", 64'(byteee), 8'hA5);
        tick;
        chk("a_done_dv", 64'(byte_dv), 0);
        chk("a_done_busy", 64'(busy), 0);
        chk("a_done_byte", 64'(byteee), 0);
        // back-to-back words through the pending buffer
        word_dv = 1; word = 16'h0102;
        q.push_back(8'h02); q.push_back(8'h01);
        tick;
        word = 16'h0304;
        q.push_back(8'h04); q.push_back(8'h03);
        chk("b2b_rdy1", 64'(word_rdy), 1);
        chk("b2b_dv1", 64'(byte_dv), 1);
        tick;
        word_dv = 0;
        chk("b2b_rdy2", 64'(word_rdy), 0);
        chk("b2b_dv2", 64'(byte_dv), 1);
        tick;
        chk("b2b_rdy3", 64'(word_rdy), 1);
        chk("b2b_dv3", 64'(byte_dv), 1);
        chk("b2b_b3", 64'(byteee), 8'h04);
        tick;
        chk("b2b_dv4", 64'(byte_dv), 1);
        tick;
        chk("b2b_end", 64'(byte_dv), 0);
        // backpressure stalls on both bytes
        word_dv = 1; word = 16'hBEEF; byte_rdy = 0;
        q.push_back(8'hEF); q.push_back(8'hBE);
        tick;
        word_dv = 0;
        chk("st_h0", 64'(byteee), 8'hEF);
        tick;
        chk("st_h1", 64'(byteee), 8'hEF);
        byte_rdy = 1;
        tick;
        chk("st_h2", 64'(byteee), 8'hBE);
        byte_rdy = 0;
        tick;
        chk("st_h3", 64'(byteee), 8'hBE);
        byte_rdy = 1;
        tick;
        chk("st_end", 64'(byte_dv), 0);
        // overflow: active and pending full, third word dropped
        byte_rdy = 0;
        word_dv = 1; word = 16'h0A0B; msb_first = 0;
        q.push_back(8'h0B); q.push_back(8'h0A);
        tick;
        word = 16'h0C0D; msb_first = 1;
        q.push_back(8'h0C); q.push_back(8'h0D);
        tick;
        chk("ov_rdy", 64'(word_rdy), 0);
        chk("ov_pre", 64'(ovf), 0);
        word = 16'hDEAD; msb_first = 0;
        tick;
        word_dv = 0;
        chk("ov_set", 64'(ovf), 64'(OVF_EXP));
        byte_rdy = 1;
        drain;
        chk("ov_sticky", 64'(ovf), 64'(OVF_EXP));
        ovf_clr = 1;
        tick;
        ovf_clr = 0;
        chk("ov_clr", 64'(ovf), 0);
        // reset after the first byte discards the rest
        word_dv = 1; word = 16'h1234; msb_first = 0;
        q.push_back(8'h34); q.push_back(8'h12);
        tick;
        word_dv = 0;
        chk("r_b0", 64'(byteee), 8'h34);
        tick;
        rst = 1;
        q.delete();
        tick;
        rst = 0;
        chk("r_dv", 64'(byte_dv), 0);
        chk("r_byte", 64'(byteee), 0);
        chk("r_busy", 64'(busy), 0);
        chk("r_rdy", 64'(word_rdy), 1);
        tick;
        chk("r_quiet", 64'(byte_dv), 0);
        drain;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
